// File: rtl/i2c_temp_slave.sv
`timescale 1ns/1ps
// i2c_temp_slave: I2C target emulating the board temperature sensor.
// Oversamples SCL/SDA on clk_50MHz and serves a 4-entry register map:
// 0 temp MSB, 1 temp LSB, 2 config (host writable), 3 device ID.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in the 8-bit address byte
// ADDR_ACK | driving the address ACK during the 9th clock
// WR_DATA  | shifting in a byte written by the master
// WR_ACK   | driving the data ACK during the 9th clock
// RD_DATA  | shifting a register byte out, MSB first
// RD_ACK   | sampling the master's ACK/NACK on the 9th clock
// IGNORE   | not addressed or read finished, waiting for START/STOP
module i2c_temp_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h4B,
  parameter logic [7:0] DEVICE_ID  = 8'hCB
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_in,
  output logic [7:0]  cfg_out,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [6:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        first_q, first_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [15:0] snap_q, snap_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  function automatic logic [7:0] reg_byte(input logic [1:0]  p,
                                          input logic [15:0] t,
                                          input logic [7:0]  c);
    case (p)
      2'd0:    reg_byte = t[15:8];
      2'd1:    reg_byte = t[7:0];
      2'd2:    reg_byte = c;
      default: reg_byte = DEVICE_ID;
    endcase
  endfunction

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte   = {shift_q, sda_s};

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign cfg_out = cfg_q;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;

  // Pin synchronizers plus previous-value registers; reset to the idle-bus level
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 7'd0;
      tx_q      <= 7'd0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      ptr_q     <= 2'd0;
      cfg_q     <= 8'h00;
      snap_q    <= 16'h0000;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      ptr_q     <= ptr_d;
      cfg_q     <= cfg_d;
      snap_q    <= snap_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Next-state logic: STOP and START override every state, SDA drive moves only on SCL falls
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    first_d   = first_q;
    ptr_d     = ptr_q;
    cfg_d     = cfg_q;
    snap_d    = snap_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rd_done_d = 1'b0;
    tx_byte   = 8'h00;

    if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else if (rw_q) begin
              // Snapshot keeps MSB/LSB coherent for the whole read
              snap_d    = temp_in;
              tx_byte   = reg_byte(ptr_q, temp_in, cfg_q);
              sda_oe_d  = ~tx_byte[7];
              tx_d      = tx_byte[6:0];
              bit_cnt_d = 4'd1;
              state_d   = RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              first_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = WR_ACK;
              if (first_q) begin
                ptr_d   = rx_byte[1:0];
                first_d = 1'b0;
              end else begin
                if (ptr_q == 2'd2) cfg_d = rx_byte;
                ptr_d = ptr_q + 2'd1;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d  = ~tx_q[6];
              tx_d      = {tx_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (bit_cnt_q == 4'd0) begin
            if (scl_rise) begin
              ptr_d = ptr_q + 2'd1;
              if (sda_s) begin
                rd_done_d = 1'b1;
                state_d   = IGNORE;
              end else begin
                bit_cnt_d = 4'd1;
              end
            end
          end else if (scl_fall) begin
            tx_byte   = reg_byte(ptr_q, snap_q, cfg_q);
            sda_oe_d  = ~tx_byte[7];
            tx_d      = tx_byte[6:0];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_slave.sv
`timescale 1ns/1ps
// Bench for i2c_temp_slave: a bit-banged I2C master drives directed
// transactions, expected responses go into a queue, and a monitor
// compares them against what the master and pin watchers observe.
module tb_i2c_temp_slave;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        m_oe = 1'b0;
  logic [15:0] temp = 16'h0C80;
  logic [7:0]  cfg;
  logic        busy, rd_done;
  wire         sda_w;

  pullup (sda_w);
  assign sda_w = m_oe ? 1'b0 : 1'bz;

  i2c_temp_slave dut (
    .clk_50MHz (clk),
    .reset     (rst),
    .SCL       (scl_m),
    .SDA       (sda_w),
    .temp_in   (temp),
    .cfg_out   (cfg),
    .busy      (busy),
    .rd_done   (rd_done)
  );

  always #10 clk = ~clk;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   obs_q[$];
  int   checks = 0;
  int   failures = 0;

  time  t_moe = 0;
  time  t_scl_fall = 0;
  int   edge_viol = 0;
  int   rd_cnt = 0;
  int   rd_wide = 0;
  logic rd_prev = 1'b0;

  task automatic expect_v(input string n, input int v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int v);
    obs_q.push_back(v);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        int   a;
        exp_t e;
        a = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_observation actual=%0h required=none", a);
        end else begin
          e = exp_q.pop_front();
          if (a != e.val) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", e.name, a, e.val);
          end
        end
      end
    end
  end

  // rd_done pulse counter and width watcher
  initial begin
    forever begin
      @(negedge clk);
      if (rd_done) begin
        if (rd_prev) rd_wide++;
        else rd_cnt++;
      end
      rd_prev = rd_done;
    end
  end

  // Slave-driven SDA transitions must follow an SCL fall by <=80 ns
  initial begin
    forever begin
      @(sda_w);
      if (!rst && !m_oe && $time != t_moe) begin
        if (scl_m || ($time - t_scl_fall) > 80) edge_viol++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_sda(input logic b);
    m_oe  = !b;
    t_moe = $time;
  endtask

  task automatic scl_set(input logic v);
    scl_m = v;
    if (!v) t_scl_fall = $time;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      drive_sda(1'b1); #T;
      scl_set(1'b1); #T;
    end
    drive_sda(1'b0); #T;
    scl_set(1'b0); #T;
  endtask

  task automatic i2c_stop();
    drive_sda(1'b0); #T;
    scl_set(1'b1); #T;
    drive_sda(1'b1); #T;
  endtask

  task automatic wr_bit(input logic b);
    drive_sda(b); #T;
    scl_set(1'b1); #T;
    scl_set(1'b0); #T;
  endtask

  task automatic rd_bit(output logic b);
    drive_sda(1'b1); #T;
    scl_set(1'b1); #(T/2);
    b = sda_w; #(T/2);
    scl_set(1'b0); #T;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    observe(int'(a));
  endtask

  task automatic rd_byte(input logic nack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack);
    observe(int'(d));
  endtask

  initial begin
    logic b;
    // reset values
    #45;
    expect_v("rst_busy", 0);    observe(int'(busy));
    expect_v("rst_cfg", 0);     observe(int'(cfg));
    expect_v("rst_rd_done", 0); observe(int'(rd_done));
    expect_v("rst_sda", 1);     observe(int'(sda_w));
    rst = 1'b0;
    #60;

    // pointer set then read
    expect_v("t1_ack_addr_w", 0);
    expect_v("t1_ack_ptr", 0);
    expect_v("t1_ack_addr_r", 0);
    expect_v("t1_rd_msb", 8'h0C);
    expect_v("t1_rd_lsb", 8'h80);
    expect_v("t1_busy_before_stop", 1);
    expect_v("t1_busy_after_stop", 0);
    expect_v("t1_rd_done_count", 1);
    i2c_start(); wr_byte(8'h96); wr_byte(8'h00);
    i2c_start(); wr_byte(8'h97); rd_byte(1'b0); rd_byte(1'b1);
    observe(int'(busy));
    i2c_stop(); #T;
    observe(int'(busy));
    observe(rd_cnt);

    // config write, then read device ID at pointer 3
    expect_v("t2_ack_addr_w", 0);
    expect_v("t2_ack_ptr", 0);
    expect_v("t2_ack_cfg", 0);
    expect_v("t2_cfg_out", 8'h5A);
    expect_v("t2_ack_addr_r", 0);
    expect_v("t2_rd_id", 8'hCB);
    expect_v("t2_rd_done_count", 2);
    i2c_start(); wr_byte(8'h96); wr_byte(8'h02); wr_byte(8'h5A);
    observe(int'(cfg));
    i2c_stop(); #T;
    i2c_start(); wr_byte(8'h97); rd_byte(1'b1);
    i2c_stop(); #T;
    observe(rd_cnt);

    // pointer wrap and snapshot coherency
    expect_v("t3_ack_addr_w", 0);
    expect_v("t3_ack_ptr", 0);
    expect_v("t3_ack_addr_r", 0);
    expect_v("t3_rd_id", 8'hCB);
    expect_v("t3_rd_msb", 8'h0C);
    expect_v("t3_rd_lsb_snapshot", 8'h80);
    expect_v("t3_rd_done_count", 3);
    i2c_start(); wr_byte(8'h96); wr_byte(8'h03);
    i2c_stop(); #T;
    i2c_start(); wr_byte(8'h97); rd_byte(1'b0);
    temp = 16'h1234;
    rd_byte(1'b0); rd_byte(1'b1);
    i2c_stop(); #T;
    observe(rd_cnt);

    // wrong address is never ACKed and writes are ignored
    expect_v("t4_nack_addr", 1);
    expect_v("t4_busy_ignore", 1);
    expect_v("t4_nack_data", 1);
    expect_v("t4_busy_after_stop", 0);
    expect_v("t4_cfg_unchanged", 8'h5A);
    i2c_start(); wr_byte(8'h90);
    observe(int'(busy));
    wr_byte(8'h02);
    i2c_stop(); #T;
    observe(int'(busy));
    observe(int'(cfg));

    // STOP mid-byte during a read of config (pointer 2)
    expect_v("t5_ack_addr_r", 0);
    expect_v("t5_rd_bit7", 0);
    expect_v("t5_busy_after_stop", 0);
    expect_v("t5_sda_released", 1);
    expect_v("t5_rd_done_count", 3);
    i2c_start(); wr_byte(8'h97);
    rd_bit(b);
    observe(int'(b));
    i2c_stop();
    observe(int'(busy));
    observe(int'(sda_w));
    observe(rd_cnt);

    // reset while the slave drives the address ACK
    expect_v("t6_ack_driven", 0);
    expect_v("t6_sda_after_reset", 1);
    expect_v("t6_busy_after_reset", 0);
    expect_v("t6_cfg_after_reset", 0);
    expect_v("t6_rd_done_after_reset", 0);
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(((8'h96 >> i) & 8'h01) != 8'h00);
    drive_sda(1'b1); #T;
    scl_set(1'b1); #(T/2);
    observe(int'(sda_w));
    rst = 1'b1;
    #1;
    observe(int'(sda_w));
    observe(int'(busy));
    observe(int'(cfg));
    observe(int'(rd_done));
    #99;
    rst = 1'b0;
    #T;
    drive_sda(1'b0); #T;
    drive_sda(1'b1); #T;
    expect_v("t6_busy_idle", 0);
    expect_v("t6_ack_addr_r", 0);
    expect_v("t6_rd_ptr0_after_reset", 8'h12);
    expect_v("t6_rd_done_count", 4);
    observe(int'(busy));
    i2c_start(); wr_byte(8'h97); rd_byte(1'b1);
    i2c_stop(); #T;
    observe(rd_cnt);

    expect_v("sda_edge_violations", 0);
    expect_v("rd_done_wide_pulses", 0);
    observe(edge_viol);
    observe(rd_wide);

    repeat (5) @(negedge clk);
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", obs_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
